// File: rtl/screen_fb.sv
// screen_fb -- double-buffered bitmap framebuffer with palette scanout.
//
// Two pages of WPF 16-bit words live in one VRAM. The CPU port always
// addresses the back page; the video side streams the front page out through
// a palette to r/g/b. A page flip is requested with flip_req and takes effect
// on the next rising edge of vsync (outside the active display).
//
// Optional build macro: SCREEN_FB_PALETTE_EN
//   defined   -> writable palette registers (pal_we/pal_index/pal_rgb)
//   undefined -> fixed grayscale ramp, palette write port ignored
//
// Ports:
//   clk, reset             single clock, asynchronous active-low reset
//   cpu_in/cpu_load        back-page write data and strobe
//   cpu_address            word address within the back page
//   cpu_out                registered back-page read data (old data on RDW)
//   flip_req/flip_ack      flip request pulse / one-cycle flip-done pulse
//   front_page             page currently being scanned out
//   pix_ce                 pixel clock enable; scanout only advances on it
//   display_on, vsync      timing from the sync generator
//   pal_we/pal_index/pal_rgb palette write port
//   r, g, b, de            pixel colour and data enable, 2 pix_ce ticks late
module screen_fb #(
    parameter int H_ACTIVE = 512,
    parameter int V_ACTIVE = 256,
    parameter int BPP      = 1,
    localparam int WPF     = H_ACTIVE * V_ACTIVE * BPP / 16,
    localparam int AW      = $clog2(WPF)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [15:0]   cpu_in,
    input  logic          cpu_load,
    input  logic [AW-1:0] cpu_address,
    output logic [15:0]   cpu_out,
    input  logic          flip_req,
    output logic          flip_ack,
    output logic          front_page,
    input  logic          pix_ce,
    input  logic          display_on,
    input  logic          vsync,
    input  logic          pal_we,
    input  logic [3:0]    pal_index,
    input  logic [23:0]   pal_rgb,
    output logic [7:0]    r,
    output logic [7:0]    g,
    output logic [7:0]    b,
    output logic          de
);

    localparam int PPW = 16 / BPP;
    localparam int PCW = $clog2(PPW);
    localparam int NC  = 1 << BPP;

    logic [15:0]    vram [2*WPF];
    logic [AW:0]    back_addr;
    logic [AW:0]    front_addr;
    logic [AW-1:0]  word_idx;
    logic [PCW-1:0] pix_cnt;
    logic [15:0]    shreg;
    logic [BPP-1:0] pix_idx;
    logic           de_d1;
    logic           de_d2;
    logic           vsync_q;
    logic           pending;
    logic [23:0]    lut_rgb;

    function automatic logic [7:0] ramp(input int i);
        return 8'((i * 255) / (NC - 1));
    endfunction

    function automatic logic [AW:0] page_addr(input logic page, input logic [AW-1:0] a);
        return page ? (AW+1)'(WPF) + {1'b0, a} : {1'b0, a};
    endfunction

    assign back_addr  = page_addr(~front_page, cpu_address);
    assign front_addr = page_addr(front_page, word_idx);

    // VRAM itself is never reset so contents survive a reset pulse.
    always_ff @(posedge clk) begin
        if (cpu_load)
            vram[back_addr] <= cpu_in;
    end

    // CPU readback and page-flip control.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cpu_out    <= '0;
            vsync_q    <= 1'b0;
            pending    <= 1'b0;
            front_page <= 1'b0;
            flip_ack   <= 1'b0;
        end else begin
            cpu_out  <= vram[back_addr];
            vsync_q  <= vsync;
            flip_ack <= 1'b0;
            // Only a request already pending before the vsync rise is honoured;
            // a request on the rise itself waits for the following frame.
            if (vsync && !vsync_q && pending && !display_on) begin
                front_page <= ~front_page;
                pending    <= 1'b0;
                flip_ack   <= 1'b1;
            end else if (flip_req) begin
                pending <= 1'b1;
            end
        end
    end

    // Scanout pipeline: tick T fetches the word (pixel 0 at LSB), T+1 latches
    // the pixel index, T+2 registers the palette colour.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            word_idx <= '0;
            pix_cnt  <= '0;
            shreg    <= '0;
            pix_idx  <= '0;
            de_d1    <= 1'b0;
            de_d2    <= 1'b0;
            de       <= 1'b0;
            r        <= '0;
            g        <= '0;
            b        <= '0;
        end else if (pix_ce) begin
            pix_idx <= shreg[BPP-1:0];
            de_d1   <= display_on;
            de_d2   <= de_d1;
            de      <= de_d2;
            if (de_d2)
                {r, g, b} <= lut_rgb;
            else
                {r, g, b} <= '0;

            if (display_on && pix_cnt == '0)
                shreg <= vram[front_addr];
            else
                shreg <= shreg >> BPP;

            if (vsync && !display_on) begin
                word_idx <= '0;
                pix_cnt  <= '0;
            end else if (display_on) begin
                pix_cnt <= (pix_cnt == PCW'(PPW - 1)) ? '0 : pix_cnt + 1'b1;
                if (pix_cnt == '0)
                    word_idx <= (word_idx == AW'(WPF - 1)) ? '0 : word_idx + 1'b1;
            end
        end
    end

`ifdef SCREEN_FB_PALETTE_EN
    logic [7:0] pal_r [NC];
    logic [7:0] pal_g [NC];
    logic [7:0] pal_b [NC];
    logic       pal_unused;

    assign pal_unused = ^pal_index;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NC; i++) begin
                pal_r[i] <= ramp(i);
                pal_g[i] <= ramp(i);
                pal_b[i] <= ramp(i);
            end
        end else if (pal_we) begin
            pal_r[pal_index[BPP-1:0]] <= pal_rgb[23:16];
            pal_g[pal_index[BPP-1:0]] <= pal_rgb[15:8];
            pal_b[pal_index[BPP-1:0]] <= pal_rgb[7:0];
        end
    end

    assign lut_rgb = {pal_r[pix_idx], pal_g[pix_idx], pal_b[pix_idx]};
`else
    logic pal_unused;

    assign pal_unused = ^{pal_we, pal_index, pal_rgb};
    assign lut_rgb    = {3{ramp(int'(pix_idx))}};
`endif

endmodule

// File: tb/tb_screen_fb.sv
module tb_screen_fb;

    localparam int H = 32;
    localparam int V = 2;

`ifdef SCREEN_FB_PALETTE_EN
    localparam logic [23:0] LIT1 = 24'hFF0000;
    localparam logic [23:0] LIT2 = 24'hFF0000;
`else
    localparam logic [23:0] LIT1 = 24'hFFFFFF;
    localparam logic [23:0] LIT2 = 24'h555555;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic        cpu_load, flip_req, pix_ce, display_on, vsync, pal_we;
    logic [3:0]  pal_index;
    logic [23:0] pal_rgb;
    logic [15:0] cpu_in1, cpu_in2, cpu_out1, cpu_out2;
    logic [1:0]  addr1;
    logic [2:0]  addr2;
    logic        flip_ack1, flip_ack2, front1, front2, de1, de2;
    logic [7:0]  r1, g1, b1, r2, g2, b2;
    logic [15:0] wtab [4];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    screen_fb #(.H_ACTIVE(H), .V_ACTIVE(V), .BPP(1)) dut1 (
        .clk(clk), .reset(reset), .cpu_in(cpu_in1), .cpu_load(cpu_load),
        .cpu_address(addr1), .cpu_out(cpu_out1), .flip_req(flip_req),
        .flip_ack(flip_ack1), .front_page(front1), .pix_ce(pix_ce),
        .display_on(display_on), .vsync(vsync), .pal_we(pal_we),
        .pal_index(pal_index), .pal_rgb(pal_rgb), .r(r1), .g(g1), .b(b1), .de(de1)
    );

    screen_fb #(.H_ACTIVE(H), .V_ACTIVE(V), .BPP(2)) dut2 (
        .clk(clk), .reset(reset), .cpu_in(cpu_in2), .cpu_load(cpu_load),
        .cpu_address(addr2), .cpu_out(cpu_out2), .flip_req(flip_req),
        .flip_ack(flip_ack2), .front_page(front2), .pix_ce(pix_ce),
        .display_on(display_on), .vsync(vsync), .pal_we(pal_we),
        .pal_index(pal_index), .pal_rgb(pal_rgb), .r(r2), .g(g2), .b(b2), .de(de2)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Expected grey level of pixel n on line 0 of the written page.
    function automatic logic [7:0] exp1(input int n);
        return (n == 0 || n == 31) ? 8'd255 : 8'd0;
    endfunction

    function automatic logic [7:0] exp2(input int n);
        case (n)
            1:       return 8'd85;
            2:       return 8'd170;
            3:       return 8'd255;
            default: return 8'd0;
        endcase
    endfunction

    initial begin
        wtab = '{16'h0001, 16'h8000, 16'h1234, 16'h0000};
        reset = 1'b0; cpu_load = 0; flip_req = 0; pix_ce = 1; display_on = 0;
        vsync = 0; pal_we = 0; pal_index = 0; pal_rgb = 0;
        cpu_in1 = 0; cpu_in2 = 0; addr1 = 0; addr2 = 0;
        step(); step();
        check("rst_rgb1", {r1, g1, b1}, 0);
        check("rst_de1", de1, 0);
        check("rst_front1", front1, 0);
        check("rst_ack1", flip_ack1, 0);
        check("rst_cpu_out1", cpu_out1, 0);
        check("rst_rgb2", {r2, g2, b2}, 0);
        check("rst_de2", de2, 0);

        reset = 1'b1;
        step();

        // Fill back page (page 1) of both instances.
        cpu_load = 1;
        for (int i = 0; i < 8; i++) begin
            addr2   = 3'(i);
            addr1   = 2'(i % 4);
            cpu_in2 = (i == 0) ? 16'h00E4 : 16'h0000;
            cpu_in1 = wtab[i % 4];
            step();
        end

        // Read during write returns the old word.
        addr1 = 2; cpu_in1 = 16'hBEEF; addr2 = 3; cpu_in2 = 16'h0000;
        step();
        check("rdw_old", cpu_out1, 16'h1234);
        cpu_load = 0; addr2 = 0;
        step();
        check("rdw_new", cpu_out1, 16'hBEEF);
        check("rd_word0_bpp2", cpu_out2, 16'h00E4);

        // Flip requested mid-frame, second request while pending.
        flip_req = 1; step(); flip_req = 0;
        check("flip_wait_front", front1, 0);
        check("flip_wait_ack", flip_ack1, 0);
        step(); step();
        flip_req = 1; step(); flip_req = 0; step();
        check("flip_wait2_front", front1, 0);
        vsync = 1; step();
        check("flip_front1", front1, 1);
        check("flip_ack1", flip_ack1, 1);
        check("flip_front2", front2, 1);
        step();
        check("flip_ack_pulse", flip_ack1, 0);
        check("flip_front_held", front1, 1);
        vsync = 0; step();
        vsync = 1; step();
        check("flip_single_toggle", front1, 1);
        check("flip_no_ack", flip_ack1, 0);
        vsync = 0; step();

        // One full line from page 1.
        for (int s = 0; s < 36; s++) begin
            display_on = (s < 32);
            step();
            if (s >= 2 && s < 34) begin
                check($sformatf("line1_px%0d", s - 2), {r1, g1, b1}, {3{exp1(s - 2)}});
                check($sformatf("line2_px%0d", s - 2), {r2, g2, b2}, {3{exp2(s - 2)}});
                check($sformatf("line1_de%0d", s), de1, 1);
            end else begin
                check($sformatf("line1_blank%0d", s), {r1, g1, b1, de1}, 0);
                check($sformatf("line2_blank%0d", s), {r2, g2, b2, de2}, 0);
            end
        end

        // Scanout holds while pix_ce is low.
        vsync = 1; step(); vsync = 0; step();
        display_on = 1; step(); step(); step();
        check("hold_pre", {r1, g1, b1}, 24'hFFFFFF);
        pix_ce = 0; step(); step(); step();
        check("hold_rgb", {r1, g1, b1}, 24'hFFFFFF);
        check("hold_de", de1, 1);
        pix_ce = 1; step();
        check("hold_next1", {r1, g1, b1}, 24'h000000);
        check("hold_next2", {r2, g2, b2}, 24'h555555);
        display_on = 0; step(); step(); step();

        // Palette entry 1 -> red.
        pal_we = 1; pal_index = 4'h1; pal_rgb = 24'hFF0000; step(); pal_we = 0;
        vsync = 1; step(); vsync = 0; step();
        display_on = 1; step(); step(); step();
        check("pal_px0_bpp1", {r1, g1, b1}, LIT1);
        step();
        check("pal_px1_bpp2", {r2, g2, b2}, LIT2);
        check("pre_reset_de", de1, 1);

        // Asynchronous reset mid-line.
        reset = 0; #1;
        check("arst_rgb1", {r1, g1, b1}, 0);
        check("arst_de1", de1, 0);
        check("arst_ack1", flip_ack1, 0);
        check("arst_front1", front1, 0);
        check("arst_rgb2", {r2, g2, b2}, 0);
        check("arst_de2", de2, 0);
        display_on = 0; step();
        reset = 1; addr1 = 0; addr2 = 0; step();
        check("vram_keep1", cpu_out1, 16'h0001);
        check("vram_keep2", cpu_out2, 16'h00E4);

        // Flip request on the vsync rising edge waits one frame.
        step();
        flip_req = 1; vsync = 1; step(); flip_req = 0;
        check("coinc_no_toggle", front1, 0);
        check("coinc_no_ack", flip_ack1, 0);
        step();
        check("coinc_still", front1, 0);
        vsync = 0; step(); step();
        vsync = 1; step();
        check("coinc_toggle", front1, 1);
        check("coinc_ack", flip_ack1, 1);
        step();
        check("coinc_ack_end", flip_ack1, 0);
        vsync = 0; step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/screen_fb.md
SCREEN_FB -- requirements
Module: screen_fb

Interface
REQ-001 SHALL have parameter H_ACTIVE, default 512, active pixels per line.
REQ-002 SHALL have parameter V_ACTIVE, default 256, active lines per frame.
REQ-003 SHALL have parameter BPP, default 1, bits per pixel (legal: 1, 2, 4).
REQ-004 SHALL derive WPF = H_ACTIVE*V_ACTIVE*BPP/16 (words per page) and AW = clog2(WPF).
REQ-005 SHALL have clk, input, 1, single clock for CPU and video.
REQ-006 SHALL have reset, input, 1, asynchronous active-low reset.
REQ-007 SHALL have cpu_in, input, 16, write data.
REQ-008 SHALL have cpu_load, input, 1, write strobe.
REQ-009 SHALL have cpu_address, input, AW, word address within the back page.
REQ-010 SHALL have cpu_out, output, 16, registered read data from the back page.
REQ-011 SHALL have flip_req, input, 1, page-flip request pulse.
REQ-012 SHALL have flip_ack, output, 1, one-cycle flip-done pulse.
REQ-013 SHALL have front_page, output, 1, page currently scanned out.
REQ-014 SHALL have pix_ce, display_on, vsync, inputs, 1 each, pixel enable and timing from the sync generator.
REQ-015 SHALL have pal_we, input, 1; pal_index, input, 4; pal_rgb, input, 24: palette write port.
REQ-016 SHALL have r, g, b, outputs, 8 each; de, output, 1, data enable aligned with r/g/b.

Function
REQ-017 SHALL hold 2*WPF 16-bit words; page p occupies words p*WPF .. p*WPF+WPF-1.
REQ-018 SHALL write cpu_in to back page (page !front_page) at cpu_address on clk when cpu_load=1.
REQ-019 SHALL present back-page word at cpu_address on cpu_out one clk later; read-during-write returns old data.
REQ-020 SHALL advance scanout only on cycles with pix_ce=1; all other cycles hold scanout state.
REQ-021 SHALL pack 16/BPP pixels per word, pixel 0 in bits [BPP-1:0] (LSB first).
REQ-022 SHALL fetch the next front-page word on the pix_ce where display_on=1 and the in-word pixel counter is 0, then shift right by BPP on each following pix_ce.
REQ-023 SHALL increment the word index after each fetch and clear it and the pixel counter on any pix_ce with vsync=1 and display_on=0.
REQ-024 SHALL map each pixel value through the palette to r/g/b, registered.
REQ-025 SHALL present pixel N of a line at r/g/b exactly 2 pix_ce ticks after the tick where it was scanned; de SHALL be display_on delayed identically.
REQ-026 SHALL drive r/g/b = 0 whenever de=0.
REQ-027 SHALL set a flip-pending flag on flip_req=1; a flip_req while pending SHALL be ignored.
REQ-028 SHALL on the first clk with vsync=1 after vsync=0 (rising edge) and pending set before that cycle: toggle front_page, clear pending, assert flip_ack for one cycle.
REQ-029 SHALL treat flip_req coincident with the vsync rising edge as pending for the next vsync.
REQ-030 SHALL never switch front_page while display_on=1.

Reset
REQ-031 SHALL on reset=0 asynchronously clear front_page, pending, flip_ack, cpu_out, word index, pixel counter, shift register, r, g, b, de.
REQ-032 SHALL load the palette with a grayscale ramp: entry i = i*255/(2^BPP-1) on all three channels (BPP=1: 0,255; BPP=2: 0,85,170,255; BPP=4: i*17).
REQ-033 SHALL leave VRAM contents unchanged by reset.

Configuration
REQ-034 SHALL, with SCREEN_FB_PALETTE_EN defined, write pal_rgb[23:16]/[15:8]/[7:0] to entry pal_index (R/G/B) on clk when pal_we=1, index masked to BPP bits, effective from the next pixel.
REQ-035 SHALL, without SCREEN_FB_PALETTE_EN, use the fixed grayscale ramp of REQ-032 and ignore pal_we, pal_index, pal_rgb.

Verification
REQ-036 SHALL test BPP=1: write 16'h0001 to back page word 0, flip, next frame -> pixel 0 = 255/255/255, pixels 1-15 = 0, 2 pix_ce latency, de aligned.
REQ-037 SHALL test BPP=2: front word 16'hE4 -> pixels 0..3 = 0,85,170,255.
REQ-038 SHALL test flip: flip_req mid-frame -> front_page unchanged until vsync rise, then toggles, flip_ack high exactly 1 cycle; second flip_req while pending -> single toggle.
REQ-039 SHALL test flip_req on vsync rise cycle -> no toggle that frame, toggle at following vsync.
REQ-040 SHALL test palette (macro on): pal_we index 1 rgb 24'hFF0000 -> lit pixels red; macro off -> remains 255/255/255.
REQ-041 SHALL test reset asserted mid-line -> r/g/b/de/flip_ack/front_page = 0 immediately; VRAM readback via cpu_out unchanged after release.
